bellek_asamasi: RTL and testbench

- Memory stage, directly downstream of the execute stage. Consumes its address, store data, load/store code, read/write strobes and writeback fields.
- Runs one load/store transaction at a time against the data-memory port using a valid/ready request and a valid response.
- Aligns and sign-extends load data, and forwards non-memory results to writeback with one registered cycle.
- Stalls the pipeline while a transaction is in flight.

---
 rtl/bellek_asamasi.sv | 193 +++++++++++++++++++
 tb/tb_bellek_asamasi.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bellek_asamasi.sv
// Memory stage: issues one load/store at a time over a valid/ready request port,
// aligns/extends load data and passes non-memory results through with one register stage.
module bellek_asamasi #(
  parameter int ZAMAN_ASIMI = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        durdur_i,
  input  logic [31:0] bellek_adresi_i,
  input  logic [31:0] bellek_veri_i,
  input  logic [2:0]  load_save_buyrugu_i,
  input  logic        bellekten_oku_i,
  input  logic        bellege_yaz_i,
  input  logic [31:0] hedef_yazmac_verisi_i,
  input  logic        yazmaca_yaz_i,
  input  logic [4:0]  hedef_yazmaci_i,
  output logic        istek_gecerli_o,
  input  logic        istek_hazir_i,
  output logic [31:0] istek_adres_o,
  output logic        istek_yaz_o,
  output logic [31:0] istek_veri_o,
  output logic [3:0]  istek_maske_o,
  input  logic        yanit_gecerli_i,
  input  logic [31:0] yanit_veri_i,
  output logic        bellek_stall_o,
  output logic        yazmaca_yaz_o,
  output logic [4:0]  hedef_yazmaci_o,
  output logic [31:0] hedef_yazmac_verisi_o,
  output logic        bellek_hata_o,
  output logic [1:0]  bellek_hata_kodu_o,
  output logic [1:0]  durum_o
);

  localparam logic [1:0] BOSTA = 2'd0;
  localparam logic [1:0] ISTEK = 2'd1;
  localparam logic [1:0] YANIT = 2'd2;
  localparam logic [1:0] BITTI = 2'd3;
  localparam logic [9:0] SON   = 10'(ZAMAN_ASIMI - 1);

  // Handshake: a request is offered while istek_gecerli_o=1 and is taken on the
  // rising edge where istek_hazir_i=1; fields stay frozen until then. Read data is
  // taken on any edge in YANIT with yanit_gecerli_i=1 and ignored in other states.

  logic [1:0]  durum;
  logic [9:0]  sayac;
  logic [1:0]  kayit_lsb;
  logic [2:0]  kayit_kod;
  logic [4:0]  kayit_rd;
  logic        kayit_wen;

  logic        bellek_islemi, kod_gecersiz, hizasiz, kabul;
  logic        hata_11, hata_01, gecerli_islem, sinir;
  logic [31:0] yaz_verisi;
  logic [3:0]  yaz_maskesi;
  logic [7:0]  secili_bayt;
  logic [15:0] secili_yarim;
  logic [31:0] yuklenen;

  assign bellek_islemi = bellekten_oku_i ^ bellege_yaz_i;
  assign kod_gecersiz  = (load_save_buyrugu_i == 3'b011) || (load_save_buyrugu_i == 3'b110) ||
                         (load_save_buyrugu_i == 3'b111) || (load_save_buyrugu_i[2] && bellege_yaz_i);
  assign hizasiz       = ((load_save_buyrugu_i[1:0] == 2'b01) && bellek_adresi_i[0]) ||
                         ((load_save_buyrugu_i == 3'b010) && (bellek_adresi_i[1:0] != 2'b00));
  // Reset gating keeps the stall low while reset is held even if upstream still shows an op.
  assign kabul         = (durum == BOSTA) && !durdur_i && !rst_i;
  assign hata_11       = (bellekten_oku_i && bellege_yaz_i) || (bellek_islemi && kod_gecersiz);
  assign hata_01       = bellek_islemi && !kod_gecersiz && hizasiz;
  assign gecerli_islem = kabul && bellek_islemi && !kod_gecersiz && !hizasiz;
  assign sinir         = (sayac == SON);

  assign istek_gecerli_o = (durum == ISTEK);
  assign bellek_stall_o  = gecerli_islem || (durum == ISTEK) || (durum == YANIT);
  assign durum_o         = durum;

  always_comb begin
    yaz_verisi  = bellek_veri_i;
    yaz_maskesi = 4'b1111;
    case (load_save_buyrugu_i[1:0])
      2'b00: begin
        yaz_verisi  = {4{bellek_veri_i[7:0]}};
        yaz_maskesi = 4'b0001 << bellek_adresi_i[1:0];
      end
      2'b01: begin
        yaz_verisi  = {2{bellek_veri_i[15:0]}};
        yaz_maskesi = bellek_adresi_i[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  always_comb begin
    secili_bayt = yanit_veri_i[7:0];
    case (kayit_lsb)
      2'd1:    secili_bayt = yanit_veri_i[15:8];
      2'd2:    secili_bayt = yanit_veri_i[23:16];
      2'd3:    secili_bayt = yanit_veri_i[31:24];
      default: ;
    endcase
    secili_yarim = kayit_lsb[1] ? yanit_veri_i[31:16] : yanit_veri_i[15:0];
    case (kayit_kod)
      3'b000:  yuklenen = {{24{secili_bayt[7]}}, secili_bayt};
      3'b100:  yuklenen = {24'd0, secili_bayt};
      3'b001:  yuklenen = {{16{secili_yarim[15]}}, secili_yarim};
      3'b101:  yuklenen = {16'd0, secili_yarim};
      default: yuklenen = yanit_veri_i;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      durum                 <= BOSTA;
      sayac                 <= 10'd0;
      kayit_lsb             <= 2'd0;
      kayit_kod             <= 3'd0;
      kayit_rd              <= 5'd0;
      kayit_wen             <= 1'b0;
      istek_adres_o         <= 32'd0;
      istek_yaz_o           <= 1'b0;
      istek_veri_o          <= 32'd0;
      istek_maske_o         <= 4'd0;
      yazmaca_yaz_o         <= 1'b0;
      hedef_yazmaci_o       <= 5'd0;
      hedef_yazmac_verisi_o <= 32'd0;
      bellek_hata_o         <= 1'b0;
      bellek_hata_kodu_o    <= 2'b00;
    end else begin
      bellek_hata_o      <= 1'b0;
      bellek_hata_kodu_o <= 2'b00;
      case (durum)
        BOSTA: begin
          if (!durdur_i) begin
            if (hata_11 || hata_01) begin
              yazmaca_yaz_o      <= 1'b0;
              bellek_hata_o      <= 1'b1;
              bellek_hata_kodu_o <= hata_11 ? 2'b11 : 2'b01;
            end else if (bellek_islemi) begin
              yazmaca_yaz_o <= 1'b0;
              kayit_lsb     <= bellek_adresi_i[1:0];
              kayit_kod     <= load_save_buyrugu_i;
              kayit_rd      <= hedef_yazmaci_i;
              kayit_wen     <= yazmaca_yaz_i;
              istek_adres_o <= {bellek_adresi_i[31:2], 2'b00};
              istek_yaz_o   <= bellege_yaz_i;
              istek_veri_o  <= yaz_verisi;
              istek_maske_o <= bellege_yaz_i ? yaz_maskesi : 4'b1111;
              sayac         <= 10'd0;
              durum         <= ISTEK;
            end else begin
              yazmaca_yaz_o         <= yazmaca_yaz_i;
              hedef_yazmaci_o       <= hedef_yazmaci_i;
              hedef_yazmac_verisi_o <= hedef_yazmac_verisi_i;
            end
          end
        end
        ISTEK: begin
          sayac         <= sayac + 10'd1;
          yazmaca_yaz_o <= 1'b0;
          // A store accepted on the last allowed cycle has completed; a load would still need data.
          if (istek_hazir_i && istek_yaz_o) begin
            durum <= BITTI;
          end else if (sinir) begin
            durum              <= BITTI;
            bellek_hata_o      <= 1'b1;
            bellek_hata_kodu_o <= 2'b10;
          end else if (istek_hazir_i) begin
            durum <= YANIT;
          end
        end
        YANIT: begin
          sayac         <= sayac + 10'd1;
          yazmaca_yaz_o <= 1'b0;
          if (yanit_gecerli_i) begin
            yazmaca_yaz_o         <= kayit_wen;
            hedef_yazmaci_o       <= kayit_rd;
            hedef_yazmac_verisi_o <= yuklenen;
            durum                 <= BITTI;
          end else if (sinir) begin
            durum              <= BITTI;
            bellek_hata_o      <= 1'b1;
            bellek_hata_kodu_o <= 2'b10;
          end
        end
        BITTI: begin
          if (!durdur_i) begin
            yazmaca_yaz_o <= 1'b0;
            durum         <= BOSTA;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bellek_asamasi.sv
// Bench for bellek_asamasi: directed scenarios plus random load/store/ALU traffic
// checked against a rule-level model of the memory stage.
module tb_bellek_asamasi;

  localparam int ZA = 4;

  logic        clk, rst_i, durdur_i;
  logic [31:0] bellek_adresi_i, bellek_veri_i, hedef_yazmac_verisi_i, yanit_veri_i;
  logic [2:0]  load_save_buyrugu_i;
  logic        bellekten_oku_i, bellege_yaz_i, yazmaca_yaz_i, istek_hazir_i, yanit_gecerli_i;
  logic [4:0]  hedef_yazmaci_i;
  logic        istek_gecerli_o, istek_yaz_o, bellek_stall_o, yazmaca_yaz_o, bellek_hata_o;
  logic [31:0] istek_adres_o, istek_veri_o, hedef_yazmac_verisi_o;
  logic [3:0]  istek_maske_o;
  logic [4:0]  hedef_yazmaci_o;
  logic [1:0]  bellek_hata_kodu_o, durum_o;

  int test_sayisi = 0;
  int hata_sayisi = 0;
  logic [31:0] exp_q[$];

  bellek_asamasi #(.ZAMAN_ASIMI(ZA)) dut (
    .clk_i(clk), .rst_i(rst_i), .durdur_i(durdur_i),
    .bellek_adresi_i(bellek_adresi_i), .bellek_veri_i(bellek_veri_i),
    .load_save_buyrugu_i(load_save_buyrugu_i), .bellekten_oku_i(bellekten_oku_i),
    .bellege_yaz_i(bellege_yaz_i), .hedef_yazmac_verisi_i(hedef_yazmac_verisi_i),
    .yazmaca_yaz_i(yazmaca_yaz_i), .hedef_yazmaci_i(hedef_yazmaci_i),
    .istek_gecerli_o(istek_gecerli_o), .istek_hazir_i(istek_hazir_i),
    .istek_adres_o(istek_adres_o), .istek_yaz_o(istek_yaz_o),
    .istek_veri_o(istek_veri_o), .istek_maske_o(istek_maske_o),
    .yanit_gecerli_i(yanit_gecerli_i), .yanit_veri_i(yanit_veri_i),
    .bellek_stall_o(bellek_stall_o), .yazmaca_yaz_o(yazmaca_yaz_o),
    .hedef_yazmaci_o(hedef_yazmaci_o), .hedef_yazmac_verisi_o(hedef_yazmac_verisi_o),
    .bellek_hata_o(bellek_hata_o), .bellek_hata_kodu_o(bellek_hata_kodu_o),
    .durum_o(durum_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic kontrol(input string etiket, input logic [31:0] gozlenen, input logic [31:0] beklenen);
    test_sayisi++;
    if (gozlenen !== beklenen) begin
      hata_sayisi++;
      $display("FAIL %s: observed %h expected %h", etiket, gozlenen, beklenen);
    end
  endtask

  // Reference model: rules of the stage written as plain arithmetic
  function automatic logic [1:0] ref_hata(logic oku, logic yaz, logic [2:0] kod, logic [31:0] adr);
    int lane;
    lane = int'(adr % 4);
    if (oku && yaz) return 2'b11;
    if (!oku && !yaz) return 2'b00;
    if (kod == 3 || kod == 6 || kod == 7) return 2'b11;
    if (yaz && kod >= 4) return 2'b11;
    if ((kod == 1 || kod == 5) && (lane % 2) != 0) return 2'b01;
    if (kod == 2 && lane != 0) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [31:0] ref_yukle(logic [2:0] kod, int lane, logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * lane)) & 32'hFF;
    h = (w >> (16 * (lane / 2))) & 32'hFFFF;
    case (kod)
      3'd0:    return (b >= 128) ? b - 32'd256 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] ref_maske(logic yaz, logic [2:0] kod, int lane);
    if (!yaz) return 4'hF;
    if (kod == 0) return 4'(1 << lane);
    if (kod == 1) return (lane >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] ref_veri(logic [2:0] kod, logic [31:0] d);
    if (kod == 0) return (d & 32'hFF) * 32'h0101_0101;
    if (kod == 1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  // Driver tasks
  task automatic girdi(input logic oku, input logic yaz, input logic [2:0] kod, input logic [31:0] adr,
                       input logic [31:0] veri, input logic [31:0] wbd, input logic [4:0] rd, input logic wen);
    bellekten_oku_i       = oku;
    bellege_yaz_i         = yaz;
    load_save_buyrugu_i   = kod;
    bellek_adresi_i       = adr;
    bellek_veri_i         = veri;
    hedef_yazmac_verisi_i = wbd;
    hedef_yazmaci_i       = rd;
    yazmaca_yaz_i         = wen;
  endtask

  task automatic bosalt();
    girdi(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
  endtask

  // Called just after a falling edge; returns just after a falling edge.
  task automatic islem(input logic oku, input logic yaz, input logic [2:0] kod, input logic [31:0] adr,
                       input logic [31:0] veri, input logic [31:0] wbd, input logic [4:0] rd, input logic wen,
                       input int d_hazir, input int d_yanit, input logic [31:0] kelime, input int bitti_dur);
    logic [1:0]  hk;
    logic [31:0] e_adr, e_veri, e_sonuc;
    logic [3:0]  e_maske;
    int t_acc, ni, ny, lane;
    bit ok;
    hk   = ref_hata(oku, yaz, kod, adr);
    lane = int'(adr % 4);
    girdi(oku, yaz, kod, adr, veri, wbd, rd, wen);
    #1;
    if (hk != 2'b00 || !(oku ^ yaz)) begin
      kontrol("bosta_stall", bellek_stall_o, 0);
      kontrol("bosta_istek", istek_gecerli_o, 0);
      @(posedge clk); @(negedge clk); #1;
      if (hk != 2'b00) begin
        kontrol("hata_darbe", bellek_hata_o, 1);
        kontrol("hata_kodu", bellek_hata_kodu_o, hk);
        kontrol("hata_wb", yazmaca_yaz_o, 0);
      end else begin
        exp_q.push_back(wbd);
        kontrol("alu_wen", yazmaca_yaz_o, wen);
        kontrol("alu_rd", hedef_yazmaci_o, rd);
        kontrol("alu_veri", hedef_yazmac_verisi_o, exp_q.pop_front());
        kontrol("alu_hata", bellek_hata_o, 0);
      end
      return;
    end
    kontrol("kabul_stall", bellek_stall_o, 1);
    e_adr   = adr & 32'hFFFF_FFFC;
    e_veri  = ref_veri(kod, veri);
    e_maske = ref_maske(yaz, kod, lane);
    t_acc   = d_hazir + 1;
    if (yaz) begin
      ok = (t_acc <= ZA); ni = ok ? t_acc : ZA; ny = 0;
    end else if (t_acc < ZA) begin
      ni = t_acc;
      ok = (t_acc + d_yanit + 1 <= ZA);
      ny = ok ? d_yanit + 1 : ZA - t_acc;
    end else begin
      ok = 0; ni = ZA; ny = 0;
    end
    @(posedge clk); @(negedge clk);
    for (int i = 0; i < ni; i++) begin
      istek_hazir_i   = (i == d_hazir);
      yanit_gecerli_i = 1'($urandom_range(0, 1));
      yanit_veri_i    = $urandom;
      #1;
      kontrol("istek_gecerli", istek_gecerli_o, 1);
      kontrol("istek_adres", istek_adres_o, e_adr);
      kontrol("istek_yaz", istek_yaz_o, yaz);
      kontrol("istek_maske", istek_maske_o, e_maske);
      if (yaz) kontrol("istek_veri", istek_veri_o, e_veri);
      kontrol("istek_stall", bellek_stall_o, 1);
      kontrol("istek_wb", yazmaca_yaz_o, 0);
      @(posedge clk); @(negedge clk);
    end
    istek_hazir_i = 1'b0;
    for (int j = 0; j < ny; j++) begin
      yanit_gecerli_i = ok && (j == d_yanit);
      yanit_veri_i    = yanit_gecerli_i ? kelime : $urandom;
      #1;
      kontrol("yanit_istek", istek_gecerli_o, 0);
      kontrol("yanit_stall", bellek_stall_o, 1);
      kontrol("yanit_wb", yazmaca_yaz_o, 0);
      @(posedge clk); @(negedge clk);
    end
    // Completion cycle: a stray late response must have no effect.
    yanit_gecerli_i = 1'b1;
    yanit_veri_i    = $urandom;
    durdur_i        = (bitti_dur > 0);
    e_sonuc         = ref_yukle(kod, lane, kelime);
    for (int k = 0; k <= bitti_dur; k++) begin
      if (k == bitti_dur) durdur_i = 1'b0;
      #1;
      kontrol("bitti_stall", bellek_stall_o, 0);
      kontrol("bitti_istek", istek_gecerli_o, 0);
      if (ok && !yaz) begin
        exp_q.push_back(e_sonuc);
        kontrol("yukle_wen", yazmaca_yaz_o, wen);
        kontrol("yukle_rd", hedef_yazmaci_o, rd);
        kontrol("yukle_veri", hedef_yazmac_verisi_o, exp_q.pop_front());
      end else begin
        kontrol("bitti_wb", yazmaca_yaz_o, 0);
      end
      kontrol("bitti_hata", bellek_hata_o, (!ok && k == 0) ? 1 : 0);
      kontrol("bitti_kod", bellek_hata_kodu_o, (!ok && k == 0) ? 2 : 0);
      @(posedge clk); @(negedge clk);
    end
    yanit_gecerli_i = 1'b0;
    bosalt();
    #1;
    kontrol("sonra_wb", yazmaca_yaz_o, 0);
    kontrol("sonra_stall", bellek_stall_o, 0);
    kontrol("sonra_hata", bellek_hata_o, 0);
  endtask

  initial begin
    logic oku, yaz;
    logic [2:0] kod;
    logic [31:0] adr;
    int r;
    rst_i = 1'b1; durdur_i = 1'b0; istek_hazir_i = 1'b0; yanit_gecerli_i = 1'b0; yanit_veri_i = 32'd0;
    bosalt();
    repeat (2) @(negedge clk);
    kontrol("reset_istek", istek_gecerli_o, 0);
    kontrol("reset_stall", bellek_stall_o, 0);
    kontrol("reset_wb", yazmaca_yaz_o, 0);
    kontrol("reset_veri", hedef_yazmac_verisi_o, 0);
    kontrol("reset_hata", bellek_hata_o, 0);
    rst_i = 1'b0;
    @(negedge clk);

    // LB from byte 3: sign-extended 0x80
    islem(1, 0, 3'b000, 32'h1003, 32'h0, 32'h0, 5'd3, 1, 0, 0, 32'h80FF_1234, 0);
    // SH to upper half with a slow memory
    islem(0, 1, 3'b001, 32'h2002, 32'h0000_BEEF, 32'h0, 5'd0, 0, 3, 0, 32'h0, 0);
    // Misaligned LW, then an error-free op shows the pulse is gone
    islem(1, 0, 3'b010, 32'h3001, 32'h0, 32'h0, 5'd4, 1, 0, 0, 32'h0, 0);
    islem(0, 0, 3'b000, 32'h0, 32'h0, 32'h1111, 5'd9, 1, 0, 0, 32'h0, 0);
    // Invalid combinations back to back
    islem(1, 1, 3'b010, 32'h0, 32'h0, 32'h0, 5'd1, 1, 0, 0, 32'h0, 0);
    islem(0, 1, 3'b100, 32'h0, 32'h0, 32'h0, 5'd1, 1, 0, 0, 32'h0, 0);
    islem(1, 0, 3'b011, 32'h0, 32'h0, 32'h0, 5'd1, 1, 0, 0, 32'h0, 0);
    // LHU with no response: timeout
    islem(1, 0, 3'b101, 32'h4002, 32'h0, 32'h0, 5'd8, 1, 0, 10, 32'h0, 0);
    // Load result held by freeze in the completion cycle
    islem(1, 0, 3'b001, 32'h5002, 32'h0, 32'h0, 5'd12, 1, 0, 1, 32'h9876_0000, 2);

    // Non-memory stream with a freeze in between
    islem(0, 0, 3'b000, 32'h0, 32'h0, 32'hAAAA, 5'd5, 1, 0, 0, 32'h0, 0);
    girdi(0, 0, 3'b000, 32'h0, 32'h0, 32'hBBBB, 5'd6, 1);
    durdur_i = 1'b1;
    @(posedge clk); @(negedge clk); #1;
    kontrol("durdur_veri", hedef_yazmac_verisi_o, 32'hAAAA);
    kontrol("durdur_rd", hedef_yazmaci_o, 5);
    kontrol("durdur_wen", yazmaca_yaz_o, 1);
    durdur_i = 1'b0;
    @(posedge clk); @(negedge clk); #1;
    kontrol("akis_veri", hedef_yazmac_verisi_o, 32'hBBBB);
    kontrol("akis_rd", hedef_yazmaci_o, 6);

    // Reset while waiting for read data
    girdi(1, 0, 3'b010, 32'h40, 32'h0, 32'h0, 5'd7, 1);
    @(posedge clk); @(negedge clk);
    istek_hazir_i = 1'b1;
    @(posedge clk); @(negedge clk);
    istek_hazir_i = 1'b0;
    #2 rst_i = 1'b1;
    #1;
    kontrol("rst_istek", istek_gecerli_o, 0);
    kontrol("rst_stall", bellek_stall_o, 0);
    kontrol("rst_wb", yazmaca_yaz_o, 0);
    kontrol("rst_adres", istek_adres_o, 0);
    kontrol("rst_maske", istek_maske_o, 0);
    kontrol("rst_rd", hedef_yazmaci_o, 0);
    kontrol("rst_hata", bellek_hata_o, 0);
    bosalt();
    @(posedge clk); @(negedge clk);
    rst_i = 1'b0;
    yanit_gecerli_i = 1'b1; yanit_veri_i = 32'hDEAD_BEEF;
    @(posedge clk); @(negedge clk); #1;
    kontrol("gec_yanit_wb", yazmaca_yaz_o, 0);
    kontrol("gec_yanit_stall", bellek_stall_o, 0);
    yanit_gecerli_i = 1'b0;
    islem(1, 0, 3'b100, 32'h10, 32'h0, 32'h0, 5'd2, 1, 0, 0, 32'h0000_00F0, 0);

    // Random traffic
    for (int n = 0; n < 120; n++) begin
      r = $urandom_range(0, 9);
      kod = 3'($urandom_range(0, 7));
      adr = $urandom;
      if (r <= 2) begin
        oku = 0; yaz = 0;
      end else if (r <= 5) begin
        oku = 1; yaz = 0;
        case ($urandom_range(0, 4))
          0: kod = 3'd0; 1: kod = 3'd1; 2: kod = 3'd2; 3: kod = 3'd4; default: kod = 3'd5;
        endcase
      end else if (r <= 8) begin
        oku = 0; yaz = 1;
        kod = 3'($urandom_range(0, 2));
      end else begin
        oku = 1'($urandom_range(0, 1)); yaz = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 1) == 1) adr = adr & 32'hFFFF_FFFC;
      islem(oku, yaz, kod, adr, $urandom, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom,
            ($urandom_range(0, 3) == 0) ? 1 : 0);
    end

    $display("[TB] %0d tests run, %0d failed", test_sayisi, hata_sayisi);
    $finish;
  end

endmodule
